// File: rtl/inst_sram_responder_pkg.sv
// inst_sram_responder_pkg: parameter limits, LFSR seed/taps and step function for the fetch responder.
package inst_sram_responder_pkg;
  localparam int WAIT_MAX = 7;
  localparam int OUTSTANDING_MIN = 1;
  localparam int OUTSTANDING_MAX = 8;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form taps bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction
endpackage

// File: rtl/inst_sram_responder_delay_pipe.sv
// resp_delay_pipe: DEPTH-stage {valid, data} shift chain with async clear; DEPTH=0 is a wire.
module resp_delay_pipe #(
  parameter int DEPTH = 0,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);
  if (DEPTH == 0) begin : g_pass
    assign o_valid = i_valid;
    assign o_data = i_data;
  end else begin : g_chain
    logic [DEPTH-1:0] r_v;
    logic [DW-1:0] r_d [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= '0;
        for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
      end else begin
        r_v[0] <= i_valid;
        r_d[0] <= i_data;
        for (int k = 1; k < DEPTH; k++) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
    end
    assign o_valid = r_v[DEPTH-1];
    assign o_data = r_d[DEPTH-1];
  end
endmodule

// File: rtl/inst_sram_responder.sv
// inst_sram_responder: SRAM-like instruction fetch responder with in-order fixed-latency returns,
// an outstanding-request limit and optional LFSR throttling of addr_ok.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int RAM_AW = 14,
  parameter int WAIT_CYCLES = 0,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit THROTTLE_EN = 1'b0,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [31:0]       ram_rdata
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX || MAX_OUTSTANDING < OUTSTANDING_MIN ||
      MAX_OUTSTANDING > OUTSTANDING_MAX || LFSR_SEED == 16'h0) begin : g_bad_param
    $error("inst_sram_responder: parameter out of range");
  end
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_lfsr;
  logic          r_v1;
  logic          w_pv;
  logic [31:0]   w_pd;
  logic          w_unused;
  assign inst_addr_ok = !reset && inst_req && (r_cnt < MAX_CNT) && (!THROTTLE_EN || r_lfsr[0]);
  assign ram_en = inst_addr_ok;
  assign ram_addr = inst_addr[RAM_AW+1:2];
  assign w_unused = ^{inst_addr[31:RAM_AW+2], inst_addr[1:0]};
  // The RAM output register is the stage-1 data; only its valid tag lives here.
  resp_delay_pipe #(.DEPTH(WAIT_CYCLES), .DW(32)) u_pipe (
    .clk(clk),
    .rst(reset),
    .i_valid(r_v1),
    .i_data(ram_rdata),
    .o_valid(w_pv),
    .o_data(w_pd)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_lfsr <= LFSR_SEED;
      r_v1 <= 1'b0;
      inst_data_ok <= 1'b0;
      inst_rdata <= '0;
    end else begin
      assert (!(inst_data_ok && r_cnt == '0));
      assert (r_cnt <= MAX_CNT);
      r_cnt <= r_cnt + CW'(inst_addr_ok) - CW'(inst_data_ok);
      r_lfsr <= lfsr_next(r_lfsr);
      r_v1 <= inst_addr_ok;
      inst_data_ok <= w_pv;
      if (w_pv) inst_rdata <= w_pd;
    end
  end
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: four responder configurations checked against a cycle model and a
// per-instance scoreboard of expected words and their due cycles.
module tb_inst_sram_responder;
  typedef struct {
    logic [31:0] d;
    int due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [4];
  logic        req [4];
  logic [31:0] addr [4];
  logic        addr_ok [4];
  logic        data_ok [4];
  logic [31:0] rdata [4];
  logic        ram_en [4];
  logic [13:0] ram_addr [4];
  logic [31:0] ram_rdata [4];
  logic [31:0] mem [16384];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 1) ? 3 : (g == 3) ? 2 : 0;
    localparam bit T = (g == 2);
    exp_t q[$];
    int cnt = 0;
    logic [15:0] lf = 16'hACE1;
    logic eok, edok;

    inst_sram_responder #(.RAM_AW(14), .WAIT_CYCLES(W), .MAX_OUTSTANDING(2),
                          .THROTTLE_EN(T), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk),
      .reset(rst[g]),
      .inst_req(req[g]),
      .inst_addr(addr[g]),
      .inst_addr_ok(addr_ok[g]),
      .inst_data_ok(data_ok[g]),
      .inst_rdata(rdata[g]),
      .ram_en(ram_en[g]),
      .ram_addr(ram_addr[g]),
      .ram_rdata(ram_rdata[g])
    );

    always @(posedge clk) if (ram_en[g]) ram_rdata[g] <= mem[ram_addr[g]];

    always @(negedge clk) begin
      if (rst[g]) begin
        q.delete();
        cnt = 0;
        lf = 16'hACE1;
        chk($sformatf("d%0d.rst_addr_ok", g), addr_ok[g], 0);
        chk($sformatf("d%0d.rst_data_ok", g), data_ok[g], 0);
        chk($sformatf("d%0d.rst_rdata", g), rdata[g], 0);
        chk($sformatf("d%0d.rst_ram_en", g), ram_en[g], 0);
      end else begin
        eok = req[g] && cnt < 2 && (!T || lf[0]);
        edok = q.size() > 0 && q[0].due == cyc;
        chk($sformatf("d%0d.addr_ok", g), addr_ok[g], eok);
        chk($sformatf("d%0d.ram_en", g), ram_en[g], eok);
        chk($sformatf("d%0d.data_ok", g), data_ok[g], edok);
        if (eok) begin
          chk($sformatf("d%0d.ram_addr", g), ram_addr[g], addr[g][15:2]);
          q.push_back('{mem[addr[g][15:2]], cyc + 2 + W});
        end
        if (edok) begin
          chk($sformatf("d%0d.rdata", g), rdata[g], q[0].d);
          void'(q.pop_front());
        end
        cnt = cnt + int'(eok) - int'(edok);
        lf = lfsr_step(lf);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] a);
    bit done = 1'b0;
    req[i] = 1'b1;
    addr[i] = a;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      done = addr_ok[i];
      @(posedge clk);
      #1;
    end
    if (!done) chk($sformatf("d%0d.accept_timeout", i), {31'b0, addr_ok[i]}, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      req[i] = 1'b0;
      addr[i] = '0;
    end
    for (int k = 0; k < 16384; k++) mem[k] = $urandom;
    mem[16] = 32'h24020001;
    idle(3);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    // single fetch, then a held-request stream
    send(0, 32'h0000_0040);
    req[0] = 1'b0;
    idle(6);
    for (int k = 0; k < 4; k++) send(0, k * 4);
    req[0] = 1'b0;
    idle(6);
    // outstanding limit with a 3-cycle extra delay
    for (int k = 0; k < 6; k++) send(1, 32'h100 + k * 4);
    req[1] = 1'b0;
    idle(12);
    // LFSR throttling
    for (int k = 0; k < 12; k++) send(2, 32'h200 + k * 4);
    req[2] = 1'b0;
    idle(8);
    // reset with two reads in flight
    send(3, 32'h300);
    send(3, 32'h304);
    req[3] = 1'b0;
    idle(1);
    rst[3] = 1'b1;
    idle(2);
    rst[3] = 1'b0;
    send(3, 32'h308);
    req[3] = 1'b0;
    idle(8);
    // aliased, misaligned address
    send(0, 32'h0001_0043);
    req[0] = 1'b0;
    idle(8);
    chk("d0.drain", g_dut[0].q.size(), 0);
    chk("d1.drain", g_dut[1].q.size(), 0);
    chk("d2.drain", g_dut[2].q.size(), 0);
    chk("d3.drain", g_dut[3].q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
